mmio_periph: RTL and testbench

MMIO_PERIPH -- requirements
Module: mmio_periph

---
 rtl/mmio_periph_if.sv | 26 ++
 rtl/mmio_periph.sv | 158 +++++++++++++++
 tb/tb_mmio_periph.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mmio_periph_if.sv
// CPU data-bus port of the MMIO peripheral: address, store data/strobe, load data and window hit.
interface mmio_periph_if;
  logic [31:0] adr;
  logic [31:0] wdin;
  logic        we;
  logic [31:0] rd;
  logic        hit;

  // CPU side drives the address and store signals.
  modport master (
    output adr,
    output wdin,
    output we,
    input  rd,
    input  hit
  );

  // Peripheral side decodes the address and returns load data.
  modport slave (
    input  adr,
    input  wdin,
    input  we,
    output rd,
    output hit
  );
endinterface

// File: rtl/mmio_periph.sv
// Memory-mapped board peripheral: a 32-bit digit register scanned onto an 8-digit seven-segment
// display, a 24-bit LED register and a debounced 24-bit switch input.
// Window is 0xFFFFF000..0xFFFFFFFF; the low two address bits are ignored.
module mmio_periph #(
  parameter int unsigned SCAN_DIV   = 50000,
  parameter int unsigned DEB_CYCLES = 100000
) (
  input  logic                clk,
  input  logic                rst,
  mmio_periph_if.slave        bus,
  input  logic [23:0]         device_sw,
  output logic [23:0]         device_led,
  output logic [7:0]          dig_en,
  output logic [7:0]          dig_seg
);

  localparam int unsigned ScanW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned DebW  = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  localparam logic [ScanW-1:0] ScanLast = ScanW'(SCAN_DIV - 1);
  localparam logic [DebW-1:0]  DebLast  = DebW'(DEB_CYCLES - 1);

  // Word offsets (byte offset >> 2) of the mapped registers.
  localparam logic [9:0] OffDig = 10'h000;
  localparam logic [9:0] OffLed = 10'h018;
  localparam logic [9:0] OffSw  = 10'h01C;

  logic [31:0]      dig_q, dig_d;
  logic [23:0]      led_q, led_d;
  logic [23:0]      sync1_q, sync2_q;
  logic [23:0]      cand_q, cand_d;
  logic [23:0]      sw_deb_q, sw_deb_d;
  logic [DebW-1:0]  deb_cnt_q, deb_cnt_d;
  logic [ScanW-1:0] scan_cnt_q, scan_cnt_d;
  logic [2:0]       idx_q, idx_d;

  logic       hit;
  logic [9:0] off;
  logic [3:0] nibble;

  // Byte-lane bits are never decoded.
  logic unused_adr_lsb;
  assign unused_adr_lsb = ^bus.adr[1:0];

  assign hit     = (bus.adr[31:12] == 20'hFFFFF);
  assign off     = bus.adr[11:2];
  assign bus.hit = hit;

  // Store decode: only DIG and LED are writable, everything else drops the store.
  always_comb begin
    dig_d = dig_q;
    led_d = led_q;
    if (bus.we && hit) begin
      if (off == OffDig) begin
        dig_d = bus.wdin;
      end else if (off == OffLed) begin
        led_d = bus.wdin[23:0];
      end
    end
  end

  // Load mux: purely combinational from the address, so a same-cycle store reads the old value.
  always_comb begin
    bus.rd = 32'h0;
    if (hit) begin
      if (off == OffDig) begin
        bus.rd = dig_q;
      end else if (off == OffLed) begin
        bus.rd = {8'h0, led_q};
      end else if (off == OffSw) begin
        bus.rd = {8'h0, sw_deb_q};
      end
    end
  end

  // Debounce: a change restarts the stability count; a full count publishes the candidate.
  always_comb begin
    cand_d    = cand_q;
    deb_cnt_d = deb_cnt_q;
    sw_deb_d  = sw_deb_q;
    if (sync2_q != cand_q) begin
      cand_d    = sync2_q;
      deb_cnt_d = '0;
    end else if (deb_cnt_q == DebLast) begin
      sw_deb_d = cand_q;
    end else begin
      deb_cnt_d = deb_cnt_q + 1'b1;
    end
  end

  // Display scan: dwell SCAN_DIV cycles per digit, then step to the next digit (7 wraps to 0).
  always_comb begin
    scan_cnt_d = scan_cnt_q;
    idx_d      = idx_q;
    if (scan_cnt_q == ScanLast) begin
      scan_cnt_d = '0;
      idx_d      = idx_q + 3'd1;
    end else begin
      scan_cnt_d = scan_cnt_q + 1'b1;
    end
  end

  // All state, cleared asynchronously so a reset abandons any debounce or scan progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dig_q      <= 32'h0;
      led_q      <= 24'h0;
      sync1_q    <= 24'h0;
      sync2_q    <= 24'h0;
      cand_q     <= 24'h0;
      sw_deb_q   <= 24'h0;
      deb_cnt_q  <= '0;
      scan_cnt_q <= '0;
      idx_q      <= 3'd0;
    end else begin
      dig_q      <= dig_d;
      led_q      <= led_d;
      sync1_q    <= device_sw;
      sync2_q    <= sync1_q;
      cand_q     <= cand_d;
      sw_deb_q   <= sw_deb_d;
      deb_cnt_q  <= deb_cnt_d;
      scan_cnt_q <= scan_cnt_d;
      idx_q      <= idx_d;
    end
  end

  assign device_led = led_q;

  // One active-low digit enable; the nibble tracks DIG live so a store shows up at once.
  assign dig_en = ~(8'h01 << idx_q);
  assign nibble = dig_q[{idx_q, 2'b00} +: 4];

  // Hex to active-low segments {dp,g,f,e,d,c,b,a}, decimal point kept dark.
  always_comb begin
    dig_seg = 8'hFF;
    unique case (nibble)
      4'h0: dig_seg = 8'hC0;
      4'h1: dig_seg = 8'hF9;
      4'h2: dig_seg = 8'hA4;
      4'h3: dig_seg = 8'hB0;
      4'h4: dig_seg = 8'h99;
      4'h5: dig_seg = 8'h92;
      4'h6: dig_seg = 8'h82;
      4'h7: dig_seg = 8'hF8;
      4'h8: dig_seg = 8'h80;
      4'h9: dig_seg = 8'h90;
      4'hA: dig_seg = 8'h88;
      4'hB: dig_seg = 8'h83;
      4'hC: dig_seg = 8'hC6;
      4'hD: dig_seg = 8'hA1;
      4'hE: dig_seg = 8'h86;
      4'hF: dig_seg = 8'h8E;
      default: dig_seg = 8'hFF;
    endcase
  end

endmodule

// File: tb/tb_mmio_periph.sv
// Self-checking bench for mmio_periph with SCAN_DIV=4, DEB_CYCLES=3: constant vectors and
// hand sequences for the register map, scan, debounce and reset, then randomized bus/switch
// traffic against a cycle-count/sample-history reference model.
module tb_mmio_periph;

  localparam int unsigned SCAN = 4;
  localparam int unsigned DEB  = 3;
  localparam int unsigned HN   = DEB + 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] device_sw;
  logic [23:0] device_led;
  logic [7:0]  dig_en;
  logic [7:0]  dig_seg;

  mmio_periph_if bus ();

  mmio_periph #(
    .SCAN_DIV   (SCAN),
    .DEB_CYCLES (DEB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .device_sw  (device_sw),
    .device_led (device_led),
    .dig_en     (dig_en),
    .dig_seg    (dig_seg)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state.
  logic [31:0] m_dig;
  logic [23:0] m_led;
  logic [23:0] m_deb;
  int          m_scan;
  logic [23:0] m_hist [HN];

  logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  // Values seen in the most recent cycle, for constant-expectation checks.
  logic [31:0] obs_rd;
  logic [23:0] obs_led;
  logic [7:0]  obs_en;
  logic [7:0]  obs_seg;

  typedef struct {
    logic [31:0] adr;
    logic [31:0] wdin;
    logic        we;
    logic [31:0] exp_rd;
    logic        exp_hit;
    logic [23:0] exp_led;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    if (a[31:12] != 20'hFFFFF) return 32'h0;
    case ({a[11:2], 2'b00})
      12'h000: return m_dig;
      12'h060: return {8'h0, m_led};
      12'h070: return {8'h0, m_deb};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_dig  = 32'h0;
    m_led  = 24'h0;
    m_deb  = 24'h0;
    m_scan = 0;
    for (int i = 0; i < HN; i++) m_hist[i] = 24'h0;
  endtask

  // Effect of one rising edge on the model.
  task automatic model_edge();
    logic stable;
    if (bus.we && bus.adr[31:12] == 20'hFFFFF) begin
      if ({bus.adr[11:2], 2'b00} == 12'h000) m_dig = bus.wdin;
      if ({bus.adr[11:2], 2'b00} == 12'h060) m_led = bus.wdin[23:0];
    end
    m_scan = (m_scan + 1) % (SCAN * 8);
    for (int i = HN - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
    m_hist[0] = device_sw;
    // Two samples are still in the synchronizer; DEB+1 identical older samples publish.
    stable = 1'b1;
    for (int i = 3; i <= DEB + 2; i++) if (m_hist[i] !== m_hist[2]) stable = 1'b0;
    if (stable) m_deb = m_hist[2];
  endtask

  task automatic check_outputs();
    int idx;
    idx = (m_scan / SCAN) % 8;
    chk("rd", bus.rd, model_rd(bus.adr));
    chk("hit", {31'b0, bus.hit}, {31'b0, bus.adr[31:12] == 20'hFFFFF});
    chk("device_led", {8'h0, device_led}, {8'h0, m_led});
    chk("dig_en", {24'h0, dig_en}, {24'h0, ~(8'h01 << idx)});
    chk("dig_seg", {24'h0, dig_seg}, {24'h0, seg_tab[(m_dig >> (4 * idx)) & 32'hF]});
  endtask

  // Called at a negedge; drives, checks before the edge, advances model, returns at negedge.
  task automatic cycle(input logic [31:0] a, input logic [31:0] w, input logic we_v,
                       input logic [23:0] sw);
    bus.adr   = a;
    bus.wdin  = w;
    bus.we    = we_v;
    device_sw = sw;
    #1;
    obs_rd  = bus.rd;
    obs_led = device_led;
    obs_en  = dig_en;
    obs_seg = dig_seg;
    check_outputs();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  // Called at a negedge: asserts reset asynchronously, checks cleared outputs, releases.
  task automatic apply_reset();
    rst     = 1'b1;
    bus.we  = 1'b0;
    bus.adr = 32'hFFFFF000;
    #1;
    chk("rst_dig_en", {24'h0, dig_en}, 32'h0000_00FE);
    chk("rst_dig_seg", {24'h0, dig_seg}, 32'h0000_00C0);
    chk("rst_led", {8'h0, device_led}, 32'h0);
    chk("rst_rd_dig", bus.rd, 32'h0);
    bus.adr = 32'hFFFFF070;
    #1;
    chk("rst_rd_sw", bus.rd, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  logic [7:0] scan_en  [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
  logic [7:0] scan_seg [8] = '{8'h80, 8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9};

  initial begin
    logic [23:0] cur_sw;
    logic [31:0] a;
    int          hold;
    int          sel;

    vecs[0]  = '{32'hFFFFF070, 32'h0,        1'b0, 32'h0,        1'b1, 24'h0};
    vecs[1]  = '{32'hFFFFF000, 32'h12345678, 1'b1, 32'h0,        1'b1, 24'h0};
    vecs[2]  = '{32'hFFFFF000, 32'h0,        1'b0, 32'h12345678, 1'b1, 24'h0};
    vecs[3]  = '{32'hFFFFF060, 32'hFFABCDEF, 1'b1, 32'h0,        1'b1, 24'h0};
    vecs[4]  = '{32'hFFFFF060, 32'h0,        1'b0, 32'h00ABCDEF, 1'b1, 24'hABCDEF};
    vecs[5]  = '{32'h00001000, 32'hDEADBEEF, 1'b1, 32'h0,        1'b0, 24'hABCDEF};
    vecs[6]  = '{32'hFFFFF070, 32'h55555555, 1'b1, 32'h0,        1'b1, 24'hABCDEF};
    vecs[7]  = '{32'hFFFFF004, 32'h77777777, 1'b1, 32'h0,        1'b1, 24'hABCDEF};
    vecs[8]  = '{32'hFFFFF004, 32'h0,        1'b0, 32'h0,        1'b1, 24'hABCDEF};
    vecs[9]  = '{32'hFFFFF000, 32'h0,        1'b0, 32'h12345678, 1'b1, 24'hABCDEF};
    vecs[10] = '{32'hFFFFF063, 32'h0,        1'b0, 32'h00ABCDEF, 1'b1, 24'hABCDEF};
    vecs[11] = '{32'h00000060, 32'h0,        1'b0, 32'h0,        1'b0, 24'hABCDEF};
    vecs[12] = '{32'hFFFFE000, 32'h0,        1'b0, 32'h0,        1'b0, 24'hABCDEF};
    vecs[13] = '{32'hFFFFF070, 32'h0,        1'b0, 32'h0,        1'b1, 24'hABCDEF};

    rst       = 1'b1;
    bus.adr   = 32'h0;
    bus.wdin  = 32'h0;
    bus.we    = 1'b0;
    device_sw = 24'h0;
    model_reset();
    @(negedge clk);
    apply_reset();

    // Register map and decode vectors.
    for (int i = 0; i < 14; i++) begin
      cycle(vecs[i].adr, vecs[i].wdin, vecs[i].we, 24'h0);
      chk($sformatf("vec%0d_rd", i), obs_rd, vecs[i].exp_rd);
      chk($sformatf("vec%0d_hit", i), {31'b0, bus.hit}, {31'b0, vecs[i].exp_hit});
      chk($sformatf("vec%0d_led", i), {8'h0, obs_led}, {8'h0, vecs[i].exp_led});
    end

    // Scan order with DIG=0x12345678 starting from a fresh reset.
    apply_reset();
    cycle(32'hFFFFF000, 32'h12345678, 1'b1, 24'h0);
    chk("scan_pre_write_seg", {24'h0, obs_seg}, 32'hC0);
    for (int n = 1; n <= 32; n++) begin
      cycle(32'hFFFFF000, 32'h0, 1'b0, 24'h0);
      chk($sformatf("scan%0d_en", n), {24'h0, obs_en}, {24'h0, scan_en[(n / 4) % 8]});
      chk($sformatf("scan%0d_seg", n), {24'h0, obs_seg}, {24'h0, scan_seg[(n / 4) % 8]});
    end

    // Clean step reaches sw_deb 6 cycles later; a 2-cycle glitch never does.
    apply_reset();
    for (int n = 0; n <= 7; n++) begin
      cycle(32'hFFFFF070, 32'h0, 1'b0, 24'h00F00F);
      chk($sformatf("deb_step%0d", n), obs_rd, (n >= 6) ? 32'h0000F00F : 32'h0);
    end
    for (int n = 0; n < 12; n++) begin
      cycle(32'hFFFFF070, 32'h0, 1'b0, (n < 2) ? 24'h000001 : 24'h00F00F);
      chk($sformatf("deb_glitch%0d", n), obs_rd, 32'h0000F00F);
    end

    // Reset mid-scan (idx 5) with a debounce in flight.
    apply_reset();
    cycle(32'hFFFFF000, 32'h12345678, 1'b1, 24'h0);
    cycle(32'hFFFFF060, 32'h00123456, 1'b1, 24'h0);
    for (int n = 2; n < 22; n++) cycle(32'hFFFFF070, 32'h0, 1'b0, (n >= 19) ? 24'hA5A5A5 : 24'h0);
    chk("midrst_idx5_en", {24'h0, obs_en}, 32'hDF);
    apply_reset();
    for (int n = 0; n <= 6; n++) begin
      cycle(32'hFFFFF070, 32'h0, 1'b0, 24'hA5A5A5);
      chk($sformatf("midrst_en%0d", n), {24'h0, obs_en}, (n < 4) ? 32'hFE : 32'hFD);
      chk($sformatf("midrst_sw%0d", n), obs_rd, (n >= 6) ? 32'h00A5A5A5 : 32'h0);
    end

    // Randomized traffic against the model.
    cur_sw = 24'h0;
    hold   = 0;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 199) == 0) apply_reset();
      if (hold == 0) begin
        sel    = $urandom_range(0, 2);
        cur_sw = (sel == 0) ? 24'($urandom) : (cur_sw ^ (24'h1 << $urandom_range(0, 23)));
        hold   = $urandom_range(1, 6);
      end
      hold--;
      sel = $urandom_range(0, 5);
      case (sel)
        0:       a = 32'hFFFFF000;
        1:       a = 32'hFFFFF060;
        2:       a = 32'hFFFFF070;
        3:       a = {20'hFFFFF, 5'($urandom), 7'h0};
        4:       a = $urandom;
        default: a = {20'hFFFFF, 12'($urandom)};
      endcase
      a[1:0] = 2'($urandom);
      cycle(a, $urandom, 1'($urandom), cur_sw);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
